// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock.
// Define DIVIDER_SIGNED_EN to enable two's-complement division through signed_op.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] rem_q, quo_q, div_q, dvd_q;
    logic [WIDTH-1:0] new_rem, new_quo;
    logic [WIDTH-1:0] abs_dvd, abs_div;
    logic [CW-1:0]    count;
    logic             zero_q, sign_q, neg_quo, neg_rem;
    logic             signed_en, accept, last_step;
    logic [WIDTH:0]   shifted, diff;

`ifdef DIVIDER_SIGNED_EN
    assign signed_en = signed_op;
`else
    assign signed_en = signed_op & 1'b0;
`endif

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (count == CW'(WIDTH - 1));
    assign abs_dvd   = (signed_en && dividend[WIDTH-1]) ? -dividend : dividend;
    assign abs_div   = (signed_en && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The partial remainder never exceeds 2*divisor-1, so bit WIDTH of the difference is the borrow.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) next_state = CALC;
            CALC: begin
                busy = 1'b1;
                if (zero_q)         next_state = DONE;
                else if (last_step) next_state = sign_q ? FIX : DONE;
            end
            FIX: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? CALC : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        new_rem = rem_q;
        new_quo = quo_q;
        if (state == CALC) begin
            new_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            new_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        end else if (state == FIX) begin
            if (neg_quo) new_quo = -quo_q;
            if (neg_rem) new_rem = -rem_q;
        end
    end

    // A zero divisor passes through CALC once without stepping, so done lands one edge after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            dvd_q       <= '0;
            count       <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                rem_q   <= '0;
                quo_q   <= abs_dvd;
                div_q   <= abs_div;
                dvd_q   <= dividend;
                count   <= '0;
                zero_q  <= (divisor == '0);
                sign_q  <= signed_en;
                neg_quo <= signed_en && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_rem <= signed_en && dividend[WIDTH-1];
            end else if ((state == CALC && !zero_q) || state == FIX) begin
                rem_q <= new_rem;
                quo_q <= new_quo;
                if (state == CALC) count <= count + 1'b1;
            end
            if (next_state == DONE && state != DONE) begin
                quotient    <= zero_q ? '1 : new_quo;
                remainder   <= zero_q ? dvd_q : new_rem;
                div_by_zero <= zero_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider: vector table plus restart, ignore and reset-abort sequences.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_z;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Returns 1 ns after the accepting edge T with start already dropped.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1 start  = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        int lat;
        int seen;

        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 32});
        vecs.push_back('{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 32});
        vecs.push_back('{32'hFFFFFFFF,   32'h10000,      1'b0, 32'hFFFF,       32'hFFFF,       1'b0, 32});
        vecs.push_back('{32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'h1234,       1'b1, 1});
        vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0, 32});
        vecs.push_back('{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0, 32});
        vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0, 32});
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33});
        vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33});
        vecs.push_back('{32'hFFFFFFF0,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF0,   1'b1, 1});
`else
        vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, 32'h7FFFFFFC,   32'd1,          1'b0, 32});
        vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'd0,          32'h80000000,   1'b0, 32});
`endif

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", W'(busy), 0);
        checkOutput("reset_done", W'(done), 0);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_remainder", remainder, 0);
        checkOutput("reset_dbz", W'(div_by_zero), 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn);
            checkOutput($sformatf("v%0d_busy", i), W'(busy), 1);
            waitDone(lat);
            checkOutput($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
            checkOutput($sformatf("v%0d_quotient", i), quotient, vecs[i].exp_q);
            checkOutput($sformatf("v%0d_remainder", i), remainder, vecs[i].exp_r);
            checkOutput($sformatf("v%0d_dbz", i), W'(div_by_zero), W'(vecs[i].exp_z));
            checkOutput($sformatf("v%0d_busy_in_done", i), W'(busy), 0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_done_pulse", i), W'(done), 0);
        end

        // Back-to-back restart from DONE with no IDLE cycle.
        applyStimulus(32'd100, 32'd7, 1'b0);
        waitDone(lat);
        checkOutput("b2b_first_q", quotient, 14);
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("b2b_busy", W'(busy), 1);
        checkOutput("b2b_done_low", W'(done), 0);
        waitDone(lat);
        checkOutput("b2b_latency", W'(lat), 32);
        checkOutput("b2b_quotient", quotient, 4);
        checkOutput("b2b_remainder", remainder, 1);

        // A start mid-CALC must not disturb the running division.
        repeat (2) @(posedge clk);
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(lat);
        checkOutput("ignore_latency", W'(lat + 6), 32);
        checkOutput("ignore_quotient", quotient, 14);
        checkOutput("ignore_remainder", remainder, 2);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_quotient", quotient, 14);
        checkOutput("hold_remainder", remainder, 2);

        // Reset in the middle of CALC aborts with no done pulse.
        applyStimulus(32'd50, 32'd5, 1'b0);
        seen = 0;
        repeat (9) @(posedge clk);
        #1;
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("abort_busy_before", W'(busy), 1);
        repeat (9) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", W'(busy), 0);
        checkOutput("abort_done", W'(done), 0);
        checkOutput("abort_quotient", quotient, 0);
        checkOutput("abort_remainder", remainder, 0);
        checkOutput("abort_dbz", W'(div_by_zero), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        checkOutput("abort_no_done", W'(seen), 0);
        checkOutput("abort_idle_busy", W'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  meaning request a division, sampled on the rising clk edge.
REQ-005 SHALL have port signed_op  input  1  meaning two's-complement operation when high.
REQ-006 SHALL have port dividend  input  WIDTH  meaning numerator, captured when start is accepted.
REQ-007 SHALL have port divisor  input  WIDTH  meaning denominator, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  meaning a division is in progress.
REQ-009 SHALL have port done  output  1  meaning a one-cycle pulse when results are valid.
REQ-010 SHALL have port quotient  output  WIDTH  meaning result, LO-register value.
REQ-011 SHALL have port remainder  output  WIDTH  meaning result, HI-register value.
REQ-012 SHALL have port div_by_zero  output  1  meaning the last division had divisor == 0.

Function
REQ-013 SHALL implement the states IDLE, CALC, FIX and DONE as a registered FSM.
REQ-014 start SHALL be accepted in IDLE or DONE only, and SHALL be ignored in CALC and FIX.
REQ-015 On accept at edge T: latch the operands, clear the iteration counter, set busy, and go to CALC (or to DONE at T+1 if divisor == 0).
REQ-016 CALC SHALL perform one restoring step per edge: shift {rem,quo} left 1, compute the WIDTH+1-bit difference rem-divisor, keep it and set the quo LSB to 1 if no borrow, else restore and set the quo LSB to 0.
REQ-017 CALC SHALL last exactly WIDTH edges; after the last step the FSM SHALL go to FIX if signed correction is active, else to DONE.
REQ-018 FIX SHALL last one cycle and apply the sign correction, then go to DONE.
REQ-019 In DONE, done=1 and busy=0 for exactly one cycle, then the FSM SHALL go to IDLE unless start is high.
REQ-020 Unsigned latency: done SHALL be high in the cycle after edge T+WIDTH (T+32 at default).
REQ-021 Signed latency: done SHALL be high in the cycle after edge T+WIDTH+1.
REQ-022 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold until the next DONE.
REQ-023 Divide by zero: quotient SHALL be all ones, remainder SHALL equal dividend, div_by_zero SHALL be 1, and no CALC cycles SHALL occur.
REQ-024 A start in DONE SHALL be accepted and SHALL restart the FSM directly into CALC with no IDLE cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and counter=0.
REQ-026 Reset mid-CALC or mid-FIX SHALL abort the operation and SHALL NOT produce a done pulse.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro DIVIDER_SIGNED_EN SHALL control signed support.
REQ-029 With DIVIDER_SIGNED_EN defined, signed_op=1 SHALL divide the operand magnitudes in CALC.
REQ-030 With DIVIDER_SIGNED_EN defined, FIX SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend is negative.
REQ-031 With DIVIDER_SIGNED_EN defined, the result SHALL truncate toward zero, and 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0.
REQ-032 With DIVIDER_SIGNED_EN defined, a signed divide by zero SHALL give quotient all ones and remainder = dividend.
REQ-033 Without DIVIDER_SIGNED_EN, the signed_op port SHALL remain present but be ignored, all operations SHALL be unsigned, and the FIX state SHALL never be entered.

Verification
REQ-034 start, dividend=100, divisor=7, unsigned -> done after T+32, quotient=14, remainder=2, div_by_zero=0.
REQ-035 dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; then divisor=0x10000 -> quotient=0xFFFF, remainder=0xFFFF.
REQ-036 dividend=0x1234, divisor=0 -> done after T+1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-037 DIVIDER_SIGNED_EN defined, signed_op=1, -7 / 2 -> done after T+33, quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-038 start with 50/5 at T, second start with 9/3 at T+10, rst_n low for 1 cycle at T+20 -> no done pulse, all outputs 0, busy=0.
REQ-039 Back-to-back: 100/7 done, start asserted in the DONE cycle with 9/2 -> next done 32 edges later, quotient=4, remainder=1.
